// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between the EX/MEM and MEM/WB registers.
// Drives a req/gnt/rvalid data-memory bus, stalls upstream while an access
// is outstanding, and registers the MEM/WB fields for writeback.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite_EX,
  input  logic [1:0]  ResultSrc_EX,
  input  logic [1:0]  Mem_Con_EX,
  input  logic [31:0] ALUresult_EX,
  input  logic [31:0] data2_EX,
  input  logic [4:0]  rd_EX,
  input  logic [31:0] PC_next_EX,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        mem_err,
  output logic        wb_RegWrite,
  output logic [1:0]  wb_ResultSrc,
  output logic [31:0] wb_ALUresult,
  output logic [31:0] wb_rdata,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_PC_next
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [31:0]      rdata_q, rdata_n;
  logic             err_q, err_n;

  logic is_load, is_store, mem_op, misaligned, access, busy, timeout;

  assign is_load    = (Mem_Con_EX == 2'b01);
  assign is_store   = (Mem_Con_EX == 2'b10);
  assign mem_op     = is_load | is_store;
  assign misaligned = mem_op & (ALUresult_EX[1:0] != 2'b00);
  assign access     = mem_op & ~misaligned;
  assign busy       = (state == S_REQ) | (state == S_WAIT);
  // Timeout fires in the TIMEOUT_CYCLES-th cycle spent in REQ+WAIT.
  assign timeout    = busy & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  assign dmem_req   = ((state == S_IDLE) & access) | (state == S_REQ);
  assign dmem_we    = is_store;
  assign dmem_addr  = ALUresult_EX;
  assign dmem_wdata = data2_EX;
  assign stall      = access & (state != S_DONE);

  // State, timeout counter, captured load data and error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rdata_q <= rdata_n;
      err_q   <= err_n;
    end
  end

  // Next-state logic; grant handling is shared by IDLE and REQ.
  always_comb begin
    state_n = state;
    rdata_n = rdata_q;
    err_n   = err_q;
    cnt_n   = '0;
    case (state)
      S_IDLE, S_REQ: begin
        if (state == S_IDLE) err_n = 1'b0;
        if (timeout) begin
          state_n = S_DONE;
          err_n   = 1'b1;
          rdata_n = '0;
        end else if ((state == S_REQ) | access) begin
          if (!dmem_gnt) begin
            state_n = S_REQ;
          end else if (is_store) begin
            state_n = S_DONE;
          end else if (dmem_rvalid) begin
            state_n = S_DONE;
            rdata_n = dmem_rdata;
          end else begin
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (timeout) begin
          state_n = S_DONE;
          err_n   = 1'b1;
          rdata_n = '0;
        end else if (dmem_rvalid) begin
          state_n = S_DONE;
          rdata_n = dmem_rdata;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (busy & ((state_n == S_REQ) | (state_n == S_WAIT)))
      cnt_n = cnt + CNT_W'(1);
  end

  // MEM/WB register: bubble while stalled, error pulse when a faulted op retires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_RegWrite  <= 1'b0;
      wb_ResultSrc <= '0;
      wb_ALUresult <= '0;
      wb_rdata     <= '0;
      wb_rd        <= '0;
      wb_PC_next   <= '0;
      mem_err      <= 1'b0;
    end else if (stall) begin
      wb_RegWrite  <= 1'b0;
      wb_ResultSrc <= '0;
      wb_ALUresult <= '0;
      wb_rdata     <= '0;
      wb_rd        <= '0;
      wb_PC_next   <= '0;
      mem_err      <= 1'b0;
    end else begin
      wb_RegWrite  <= RegWrite_EX & ~misaligned & ~err_q;
      wb_ResultSrc <= ResultSrc_EX;
      wb_ALUresult <= ALUresult_EX;
      wb_rdata     <= (is_load & ~misaligned) ? rdata_q : '0;
      wb_rd        <= rd_EX;
      wb_PC_next   <= PC_next_EX;
      mem_err      <= misaligned | ((state == S_DONE) & err_q);
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage with a short timeout (4 cycles).
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite_EX;
  logic [1:0]  ResultSrc_EX;
  logic [1:0]  Mem_Con_EX;
  logic [31:0] ALUresult_EX;
  logic [31:0] data2_EX;
  logic [4:0]  rd_EX;
  logic [31:0] PC_next_EX;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        stall, mem_err;
  logic        wb_RegWrite;
  logic [1:0]  wb_ResultSrc;
  logic [31:0] wb_ALUresult, wb_rdata, wb_PC_next;
  logic [4:0]  wb_rd;

  int errors = 0;
  int checks = 0;

  mem_stage #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .RegWrite_EX(RegWrite_EX), .ResultSrc_EX(ResultSrc_EX), .Mem_Con_EX(Mem_Con_EX),
    .ALUresult_EX(ALUresult_EX), .data2_EX(data2_EX), .rd_EX(rd_EX), .PC_next_EX(PC_next_EX),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .stall(stall), .mem_err(mem_err),
    .wb_RegWrite(wb_RegWrite), .wb_ResultSrc(wb_ResultSrc), .wb_ALUresult(wb_ALUresult),
    .wb_rdata(wb_rdata), .wb_rd(wb_rd), .wb_PC_next(wb_PC_next)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rw, input logic [1:0] rs, input logic [1:0] mc,
                        input logic [31:0] alu, input logic [31:0] d2,
                        input logic [4:0] rd, input logic [31:0] pcn);
    RegWrite_EX = rw; ResultSrc_EX = rs; Mem_Con_EX = mc;
    ALUresult_EX = alu; data2_EX = d2; rd_EX = rd; PC_next_EX = pcn;
  endtask

  task automatic nop();
    set_op(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 32'h0);
  endtask

  initial begin
    rst = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    nop();
    #12;
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_wb_rw", wb_RegWrite, 0);
    chk("rst_wb_alu", wb_ALUresult, 0);
    tick();
    rst = 1'b1;

    // ADD: no bus activity, retires next edge
    tick();
    set_op(1'b1, 2'b00, 2'b00, 32'h7, 32'h0, 5'd3, 32'h104);
    #1;
    chk("add_req", dmem_req, 0);
    chk("add_stall", stall, 0);
    tick();
    nop();
    chk("add_wb_alu", wb_ALUresult, 32'h7);
    chk("add_wb_rw", wb_RegWrite, 1);
    chk("add_wb_rd", wb_rd, 3);
    chk("add_wb_pc", wb_PC_next, 32'h104);

    // Load 0x100, immediate gnt, rvalid next cycle
    set_op(1'b1, 2'b01, 2'b01, 32'h100, 32'h0, 5'd5, 32'h108);
    dmem_gnt = 1'b1;
    #1;
    chk("ld_req", dmem_req, 1);
    chk("ld_we", dmem_we, 0);
    chk("ld_addr", dmem_addr, 32'h100);
    chk("ld_stall1", stall, 1);
    tick();
    dmem_gnt = 1'b0;
    chk("ld_wait_req", dmem_req, 0);
    chk("ld_stall2", stall, 1);
    chk("ld_bubble", wb_RegWrite, 0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEBABE;
    tick();
    dmem_rvalid = 1'b0; dmem_rdata = '0;
    chk("ld_done_stall", stall, 0);
    chk("ld_done_req", dmem_req, 0);
    tick();
    nop();
    chk("ld_wb_rdata", wb_rdata, 32'hCAFEBABE);
    chk("ld_wb_rd", wb_rd, 5);
    chk("ld_wb_rw", wb_RegWrite, 1);
    chk("ld_wb_rs", wb_ResultSrc, 2'b01);
    chk("ld_err", mem_err, 0);

    // Store 0x20, gnt withheld 3 cycles
    set_op(1'b0, 2'b00, 2'b10, 32'h20, 32'h12345678, 5'd0, 32'h10C);
    for (int i = 0; i < 4; i++) begin
      dmem_gnt = (i == 3);
      #1;
      chk("st_req", dmem_req, 1);
      chk("st_we", dmem_we, 1);
      chk("st_wdata", dmem_wdata, 32'h12345678);
      chk("st_stall", stall, 1);
      tick();
      chk("st_bubble_alu", wb_ALUresult, 0);
      chk("st_bubble_rw", wb_RegWrite, 0);
    end
    dmem_gnt = 1'b0;
    chk("st_done_req", dmem_req, 0);
    chk("st_done_stall", stall, 0);
    tick();
    nop();
    chk("st_wb_alu", wb_ALUresult, 32'h20);
    chk("st_wb_rw", wb_RegWrite, 0);
    chk("st_wb_rdata", wb_rdata, 0);
    chk("st_err", mem_err, 0);

    // Misaligned load 0x102
    set_op(1'b1, 2'b01, 2'b01, 32'h102, 32'h0, 5'd7, 32'h110);
    dmem_gnt = 1'b1;
    #1;
    chk("mis_req", dmem_req, 0);
    chk("mis_stall", stall, 0);
    tick();
    dmem_gnt = 1'b0;
    nop();
    chk("mis_err", mem_err, 1);
    chk("mis_wb_rw", wb_RegWrite, 0);
    chk("mis_wb_alu", wb_ALUresult, 32'h102);
    tick();
    chk("mis_err_clr", mem_err, 0);

    // Load 0x40, gnt given, rvalid never: times out after 4 WAIT cycles
    set_op(1'b1, 2'b01, 2'b01, 32'h40, 32'h0, 5'd9, 32'h114);
    dmem_gnt = 1'b1;
    #1;
    chk("to_stall0", stall, 1);
    tick();
    dmem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_stall", stall, 1);
      chk("to_req", dmem_req, 0);
      tick();
    end
    chk("to_done_stall", stall, 0);
    chk("to_done_err", mem_err, 0);
    tick();
    nop();
    chk("to_err", mem_err, 1);
    chk("to_wb_rdata", wb_rdata, 0);
    chk("to_wb_rw", wb_RegWrite, 0);
    chk("to_wb_alu", wb_ALUresult, 32'h40);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1;
    chk("late_req", dmem_req, 0);
    chk("late_stall", stall, 0);
    tick();
    dmem_rvalid = 1'b0; dmem_rdata = '0;
    chk("late_err", mem_err, 0);
    chk("late_wb_rdata", wb_rdata, 0);

    // Reset asserted mid-WAIT, then a fresh load completes
    set_op(1'b1, 2'b01, 2'b01, 32'h80, 32'h0, 5'd4, 32'h118);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    chk("mw_stall", stall, 1);
    rst = 1'b0;
    nop();
    #1;
    chk("mr_req", dmem_req, 0);
    chk("mr_stall", stall, 0);
    chk("mr_wb_rw", wb_RegWrite, 0);
    chk("mr_wb_rd", wb_rd, 0);
    chk("mr_err", mem_err, 0);
    tick();
    rst = 1'b1;
    set_op(1'b1, 2'b01, 2'b01, 32'h84, 32'h0, 5'd6, 32'h11C);
    #1;
    chk("fr_idle_req", dmem_req, 1);
    chk("fr_idle_stall", stall, 1);
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h55AA33CC;
    tick();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    chk("fr_done_stall", stall, 0);
    tick();
    nop();
    chk("fr_wb_rdata", wb_rdata, 32'h55AA33CC);
    chk("fr_wb_rd", wb_rd, 6);
    chk("fr_wb_rw", wb_RegWrite, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage sitting directly downstream of the EX/MEM pipeline register.
- Consumes the EX/MEM outputs (control, ALU result, store data, rd, PC+4) and drives the data-memory bus with a req/gnt/rvalid handshake.
- Asserts stall back to the upstream pipeline registers while an access is outstanding.
- Registers the MEM/WB pipeline outputs consumed by writeback.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles spent in REQ+WAIT before the access is aborted with an error.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- RegWrite_EX  input  1  register write enable from EX/MEM.
- ResultSrc_EX  input  2  writeback select from EX/MEM: 00 ALU, 01 load data, 10 PC+4.
- Mem_Con_EX  input  2  memory op: 00 none, 01 load word, 10 store word, 11 none.
- ALUresult_EX  input  32  memory address, or ALU result for non-memory ops.
- data2_EX  input  32  store data.
- rd_EX  input  5  destination register.
- PC_next_EX  input  32  PC+4.
- dmem_req  output  1  bus request.
- dmem_we  output  1  1 = store, 0 = load.
- dmem_addr  output  32  word address (= ALUresult_EX).
- dmem_wdata  output  32  store data (= data2_EX).
- dmem_gnt  input  1  request accepted this cycle.
- dmem_rvalid  input  1  load data valid.
- dmem_rdata  input  32  load data.
- stall  output  1  freeze EX/MEM and all upstream stages.
- mem_err  output  1  one-cycle pulse on misaligned access or timeout.
- wb_RegWrite  output  1  MEM/WB: register write enable.
- wb_ResultSrc  output  2  MEM/WB: writeback select.
- wb_ALUresult  output  32  MEM/WB: ALU result.
- wb_rdata  output  32  MEM/WB: load data.
- wb_rd  output  5  MEM/WB: destination register.
- wb_PC_next  output  32  MEM/WB: PC+4.

Behaviour:
- Decode: mem_op = (Mem_Con_EX == 01 or 10); misaligned = mem_op & (ALUresult_EX[1:0] != 0).
- FSM states: IDLE, REQ, WAIT, DONE. All transitions on the rising edge of clk.
- Reset (rst = 0, asynchronous):
  - state = IDLE, counter = 0, captured rdata = 0, error flag = 0.
  - All wb_* outputs = 0.
  - Combinational outputs follow from IDLE: dmem_req = 0 when no mem_op; mem_err = 0 after reset.
  - A reset mid-access drops dmem_req immediately; any in-flight response is not tracked.
- dmem_req = (state == IDLE & mem_op & ~misaligned) | (state == REQ).
- dmem_we = (Mem_Con_EX == 10). dmem_addr and dmem_wdata are continuously driven from the EX/MEM inputs, which are stable because stall holds them.
- IDLE transitions:
  - Non-mem op or misaligned: stay in IDLE.
  - mem_op & ~gnt: go to REQ.
  - Store & gnt: go to DONE (a store completes on grant).
  - Load & gnt & rvalid in the same cycle: capture rdata, go to DONE.
  - Load & gnt & ~rvalid: go to WAIT.
- REQ: hold dmem_req until gnt, then apply the same store/load rules as IDLE.
- WAIT: dmem_req = 0. On rvalid, capture dmem_rdata and go to DONE. rvalid in IDLE, REQ-without-gnt, or DONE is ignored.
- Timeout counter:
  - Increments each cycle in REQ or WAIT; clears on entry to IDLE or DONE.
  - On reaching TIMEOUT_CYCLES: go to DONE with the error flag set and captured rdata = 0.
  - Handshakes arriving in the same cycle as the timeout are ignored.
- DONE: stall = 0. MEM/WB loads the instruction; state returns to IDLE.
- stall = mem_op & ~misaligned & (state != DONE). It is combinational, so the stall is high in the first IDLE cycle of an access.
- MEM/WB register, on every clock edge:
  - If stall: load a bubble (wb_RegWrite = 0, all other wb_* = 0).
  - Else: load the EX/MEM fields. wb_rdata = captured rdata for a load, 0 otherwise.
  - wb_RegWrite = RegWrite_EX & ~misaligned & ~error flag.
- mem_err pulses for one cycle:
  - at the edge a misaligned op is loaded into MEM/WB, or
  - at the edge a timed-out op is loaded into MEM/WB.
- Latency:
  - Non-mem op: 0 stall cycles.
  - Store with immediate gnt: 1 stall cycle.
  - Load with immediate gnt and rvalid one cycle later: 2 stall cycles.
  - Each cycle gnt is withheld adds 1 stall cycle.
- Back-to-back mem ops: the DONE→IDLE edge coincides with EX/MEM advancing, so the next op starts in the following IDLE cycle.

Test Plan:
- Reset asserted mid-WAIT → dmem_req = 0, stall = 0 with no mem_op present, all wb_* = 0, state IDLE; a fresh load then completes normally.
- Load, addr = 0x100, gnt immediate, rvalid next cycle with rdata = 0xCAFEBABE, rd = 5, ResultSrc = 01 → stall high for exactly 2 cycles, then wb_rdata = 0xCAFEBABE, wb_rd = 5, wb_RegWrite = 1.
- Store, addr = 0x20, data = 0x12345678, gnt delayed 3 cycles → dmem_req high 4 cycles with dmem_we = 1, stall high 4 cycles, MEM/WB bubble each stalled cycle, then wb_RegWrite = 0 (RegWrite_EX = 0).
- ADD (Mem_Con = 00, ALUresult = 0x7, RegWrite = 1) → no dmem_req, stall = 0, next edge wb_ALUresult = 0x7, wb_RegWrite = 1.
- Load, addr = 0x102 (misaligned) → no dmem_req, stall = 0, mem_err single pulse, wb_RegWrite = 0.
- Load, TIMEOUT_CYCLES = 4, gnt given, rvalid never asserted → stall drops after the timeout, mem_err pulse, wb_rdata = 0, wb_RegWrite = 0; a late rvalid in IDLE is ignored.
